// File: rtl/uart_rx_oversampled.sv
// UART receive engine: 2-FF synchronized rx, programmable prescaler, 3-sample majority
// vote around mid-bit, optional even/odd parity, and done/parity/framing status per frame.
`timescale 1ns/1ps
module uart_rx_oversampled #(
    parameter int DATAWIDTH    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int DIVWIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIVWIDTH-1:0]  div,
    input  logic                 parityEnable,
    input  logic                 parityType,
    input  logic                 rx,
    output logic [DATAWIDTH-1:0] rx_out,
    output logic                 rx_done,
    output logic                 parityError,
    output logic                 parityErrorValid,
    output logic                 framingError,
    output logic                 busy
);
    localparam int M  = OVERSAMPLING / 2;
    localparam int SW = $clog2(OVERSAMPLING);
    localparam int IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [1:0]            sync_pipe;
    logic                  rx_s, rx_prev;
    logic [DIVWIDTH-1:0]   pcnt, div_eff;
    logic [SW-1:0]         scnt;
    logic [IW-1:0]         bidx;
    logic [1:0]            samp;
    logic [DATAWIDTH-1:0]  shreg;
    logic                  par_en_l, par_type_l, par_bit;
    logic                  tick, start_edge, at_vote, at_wrap, vote, last_bit;

    assign rx_s       = sync_pipe[1];
    assign div_eff    = (div == '0) ? DIVWIDTH'(1) : div;
    // >= rather than == so a div shrink while idle cannot strand the counter
    assign tick       = (pcnt >= div_eff - DIVWIDTH'(1));
    assign start_edge = rx_prev & ~rx_s;
    assign at_vote    = tick && (scnt == SW'(M + 1));
    assign at_wrap    = tick && (scnt == SW'(OVERSAMPLING - 1));
    assign vote       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign last_bit   = (bidx == IW'(DATAWIDTH - 1));
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = START;
            START: begin
                if (at_vote && vote) state_next = IDLE;
                else if (at_wrap)    state_next = DATA;
            end
            DATA:    if (at_wrap && last_bit) state_next = par_en_l ? PARITY : STOP;
            PARITY:  if (at_wrap) state_next = STOP;
            STOP:    if (at_vote) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            sync_pipe        <= 2'b11;
            rx_prev          <= 1'b1;
            pcnt             <= '0;
            scnt             <= '0;
            bidx             <= '0;
            samp             <= '0;
            shreg            <= '0;
            par_en_l         <= 1'b0;
            par_type_l       <= 1'b0;
            par_bit          <= 1'b0;
            rx_out           <= '0;
            rx_done          <= 1'b0;
            parityError      <= 1'b0;
            parityErrorValid <= 1'b0;
            framingError     <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], rx};
            rx_prev   <= rx_s;
            state     <= state_next;
            rx_done   <= 1'b0;

            // restart on the start edge so ticks line up with the frame
            if ((state == IDLE && start_edge) || tick) pcnt <= '0;
            else                                       pcnt <= pcnt + DIVWIDTH'(1);

            if (state == IDLE)
                scnt <= '0;
            else if (tick)
                scnt <= (scnt == SW'(OVERSAMPLING - 1)) ? '0 : scnt + SW'(1);

            if (tick && state != IDLE) begin
                if (scnt == SW'(M - 1)) samp[0] <= rx_s;
                if (scnt == SW'(M))     samp[1] <= rx_s;
            end

            case (state)
                IDLE: begin
                    par_en_l   <= parityEnable;
                    par_type_l <= parityType;
                    bidx       <= '0;
                end
                DATA: begin
                    if (at_vote) shreg <= {vote, shreg[DATAWIDTH-1:1]};
                    if (at_wrap && !last_bit) bidx <= bidx + IW'(1);
                end
                PARITY: if (at_vote) par_bit <= vote;
                STOP: if (at_vote) begin
                    rx_out           <= shreg;
                    parityErrorValid <= par_en_l;
                    parityError      <= par_en_l & (par_bit != ((^shreg) ^ par_type_l));
                    framingError     <= ~vote;
                    rx_done          <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: a serial driver pushes the expected frame
// result, an independent monitor pops and compares on every rx_done.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] div;
    logic       parityEnable, parityType, rx;
    logic [7:0] rx_out;
    logic       rx_done, parityError, parityErrorValid, framingError, busy;

    always #5 clk = ~clk;

    uart_rx_oversampled #(.DATAWIDTH(8), .OVERSAMPLING(16), .DIVWIDTH(8)) dut (
        .clk(clk), .rst(rst), .div(div), .parityEnable(parityEnable),
        .parityType(parityType), .rx(rx), .rx_out(rx_out), .rx_done(rx_done),
        .parityError(parityError), .parityErrorValid(parityErrorValid),
        .framingError(framingError), .busy(busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       pev;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every rx_done must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (rx_done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rx_done: got rx_out=%0h expected no frame at %0t", rx_out, $time);
            end else begin
                e = q.pop_front();
                chk("rx_out", rx_out, e.d);
                chk("parityErrorValid", parityErrorValid, e.pev);
                chk("parityError", parityError, e.perr);
                chk("framingError", framingError, e.ferr);
                last = e;
            end
        end
    end

    // Serial driver. gbit: line-bit index that gets a 1-tick inverted glitch around
    // the second vote sample; nmax: number of line bits actually sent.
    task automatic send(input logic [7:0] d, input bit pen, input bit ptype, input bit pflip,
                        input bit stopv, input int bc, input int gbit, input int nmax,
                        input bit push);
        logic b[$];
        exp_t e;
        int   ones = $countones(d);
        bit   par  = ((ones % 2) != 0) ^ ptype ^ pflip;
        parityEnable = pen;
        parityType   = ptype;
        if (push) begin
            e.d    = d;
            e.pev  = pen;
            e.perr = pen && (((ones + int'(par)) % 2) != int'(ptype));
            e.ferr = !stopv;
            q.push_back(e);
        end
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (pen) b.push_back(par);
        b.push_back(stopv);
        for (int i = 0; i < b.size() && i < nmax; i++) begin
            rx = b[i];
            if (i == gbit) begin
                wait_cyc(85);
                rx = ~b[i];
                wait_cyc(10);
                rx = b[i];
                wait_cyc(bc - 95);
            end else begin
                wait_cyc(bc);
            end
        end
    endtask

    initial begin
        int t;
        int dv;
        int bc;
        rst = 1'b1; div = 8'd10; parityEnable = 1'b0; parityType = 1'b0; rx = 1'b1;
        wait_cyc(3);
        chk("reset_rx_out", rx_out, 0);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_parityError", parityError, 0);
        chk("reset_parityErrorValid", parityErrorValid, 0);
        chk("reset_framingError", framingError, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(20);

        send(8'hA5, 0, 0, 0, 1, 160, -1, 99, 1); rx = 1'b1; wait_cyc(200);
        send(8'hDB, 1, 0, 0, 1, 160, -1, 99, 1); rx = 1'b1; wait_cyc(200);
        send(8'hDB, 1, 0, 1, 1, 160, -1, 99, 1); rx = 1'b1; wait_cyc(200);
        send(8'hF1, 1, 1, 0, 1, 160, -1, 99, 1); rx = 1'b1; wait_cyc(200);
        send(8'hF1, 1, 1, 0, 0, 160, -1, 99, 1);
        // line held low past the bad stop bit: no falling edge, so no new frame
        wait_cyc(480);
        chk("no_start_while_low_busy", busy, 0);
        rx = 1'b1; wait_cyc(200);

        // short low glitch: start is detected, then rejected by the vote
        rx = 1'b0; wait_cyc(4); rx = 1'b1;
        wait_cyc(40);
        chk("glitch_start_detected_busy", busy, 1);
        wait_cyc(200);
        chk("glitch_back_idle_busy", busy, 0);
        chk("glitch_rx_out_held", rx_out, last.d);
        chk("glitch_framingError_held", framingError, last.ferr);
        chk("glitch_parityErrorValid_held", parityErrorValid, last.pev);
        chk("glitch_parityError_held", parityError, last.perr);

        // one-tick glitches in a data bit and in the start bit are outvoted
        send(8'h5A, 0, 0, 0, 1, 160, 4, 99, 1); rx = 1'b1; wait_cyc(200);
        send(8'h96, 1, 0, 0, 1, 160, 0, 99, 1); rx = 1'b1; wait_cyc(200);

        // back-to-back, last frame ~3% slow
        parityEnable = 1'b0;
        send(8'h00, 0, 0, 0, 1, 160, -1, 99, 1);
        send(8'hFF, 0, 0, 0, 1, 160, -1, 99, 1);
        send(8'h55, 0, 0, 0, 1, 165, -1, 99, 1);
        rx = 1'b1; wait_cyc(300);

        // reset in the middle of the data bits
        send(8'h3C, 0, 0, 0, 1, 160, -1, 4, 0);
        rst = 1'b1;
        wait_cyc(1);
        chk("midreset_rx_out", rx_out, 0);
        chk("midreset_rx_done", rx_done, 0);
        chk("midreset_parityError", parityError, 0);
        chk("midreset_parityErrorValid", parityErrorValid, 0);
        chk("midreset_framingError", framingError, 0);
        chk("midreset_busy", busy, 0);
        rst = 1'b0; rx = 1'b1;
        wait_cyc(300);
        send(8'h81, 0, 0, 0, 1, 160, -1, 99, 1); rx = 1'b1; wait_cyc(200);

        // randomized frames, including div=0 (treated as 1)
        for (int i = 0; i < 14; i++) begin
            dv  = $urandom_range(0, 8);
            div = 8'(dv);
            bc  = ((dv == 0) ? 1 : dv) * 16;
            send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), bc, -1, 99, 1);
            rx = 1'b1;
            wait_cyc(2 * bc + $urandom_range(0, bc));
        end

        t = 0;
        while (q.size() != 0 && t < 5000) begin
            wait_cyc(1);
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d frames outstanding expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
